audio_playback: RTL and testbench
=================================

# audio_playback

Playback stage directly downstream of the external-RAM read sequencer. On a play command it requests one 12-bit sample at a time from the reader, buffers samples in a small FIFO, and releases them at a fixed sample rate to a free-running PWM modulator driving the board's mono audio output. It sits between the RAM read sequencer and the audio amplifier pins.

## Interface
- SAMPLE_DIV, 2268: clock cycles per output sample (100 MHz / 44.1 kHz); must be at least 16.
- FIFO_DEPTH, 8: sample FIFO entries; must be a power of two, at least 2.
- Clock  input  1  system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Play  input  1  single-cycle start pulse; ignored unless the state is IDLE.
- Stop  input  1  single-cycle abort pulse; ignored in IDLE.
- Length  input  23  number of samples to play; sampled on the Play edge.
- ReadEnable  output  1  single-cycle read request to the reader (drives its Enable).
- ReadValid  input  1  single-cycle pulse; SampleIn valid this cycle.
- SampleIn  input  12  sample from the reader.
- AudioPwm  output  1  registered PWM audio bit.
- AudioSd  output  1  amplifier enable; high in FILL and PLAY.
- Busy  output  1  high in any state except IDLE.
- Done  output  1  one-cycle pulse when playback completes normally.
- Underrun  output  1  sticky; set when a sample tick finds the FIFO empty. Cleared by Reset or Play.

## Operation
- States:
  - IDLE: on Play with Length≠0, go to FILL. On Play with Length=0, pulse Done and stay in IDLE.
  - FILL: go to PLAY when the FIFO is full or all Length samples have been requested and received.
  - PLAY: go to IDLE with a Done pulse on the sample tick that consumes sample number Length.
  - Stop in FILL or PLAY: go to IDLE the next cycle and flush the FIFO. No Done pulse.
- Fetch rules:
  - ReadEnable pulses only when all of these hold:
    - state is FILL or PLAY;
    - no request is outstanding;
    - Requested < Length;
    - FIFO count is below FIFO_DEPTH.
  - The outstanding flag sets with ReadEnable and clears on ReadValid.
  - Requested is a 23-bit counter that increments with each ReadEnable.
- Stop with a request outstanding:
  - The outstanding flag persists into IDLE.
  - The late ReadValid clears the flag, and its data is discarded.
  - A Play accepted while the flag is set issues no ReadEnable until the flag clears.
- FIFO behaviour:
  - Write on ReadValid, except in IDLE or after Stop.
  - Pop on a sample tick in PLAY.
  - Simultaneous write and pop are both honoured; the count is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Sample tick:
  - A down-counter reloads SAMPLE_DIV-1 on entry to PLAY; the tick fires when it reaches 0, then it reloads.
  - On a tick with the FIFO non-empty: pop into CurSample and increment Played.
  - On a tick with the FIFO empty: hold CurSample, set Underrun, and leave Played unchanged.
- PWM:
  - PwmCnt is a free-running 12-bit counter that wraps 4095→0.
  - AudioPwm <= (PwmCnt < CurSample).
  - CurSample=0 gives a constant low output; 4095 gives a 4095/4096 duty.
  - CurSample resets to 0 and is forced to 0 in IDLE.

## Timing
- Reset values:
  - state is IDLE;
  - ReadEnable, AudioPwm, AudioSd, Busy, Done and Underrun are all 0;
  - all counters, pointers, CurSample and the outstanding flag are 0.
- Play at edge N:
  - Busy=1 and AudioSd=1 after edge N.
  - The first ReadEnable is high in the cycle after edge N+1.
- A subsequent ReadEnable may be high in the cycle after the edge that samples ReadValid, so consecutive requests are spaced by the reader latency.
- A FIFO write from ReadValid is visible in the count one cycle later.
- A popped sample appears on CurSample one cycle after the tick, and affects AudioPwm one further cycle later.
- Done is high in the first cycle of IDLE.
- Reset has priority over Play, Stop and ReadValid in the same cycle. Stop has priority over the tick.

## Structure
- Shared package (audio_pkg), containing:
  - the state encoding: IDLE, FILL, PLAY;
  - SAMPLE_W=12;
  - ADDR_W=23.
- The recording-side blocks use the same package.
- Sub-module sample_fifo (DEPTH, WIDTH parameters; synchronous, with full, empty and count outputs).
- The FSM, fetch control, tick counter and PWM stay in the top level.

## Test plan
- Basic playback: Length=3, reader model with 9-cycle latency returning 100, 2000, 4095.
  - Exactly 3 ReadEnable pulses.
  - CurSample steps 100→2000→4095 at SAMPLE_DIV intervals.
  - Done is pulsed once.
  - AudioPwm duty over 4096 cycles equals CurSample.
- Length=0: Play → Done pulses the next cycle, no ReadEnable, Busy stays 0.
- FIFO full: Length=20 with FIFO_DEPTH=8.
  - FIFO count never exceeds 8.
  - No ReadEnable while the FIFO is full.
  - 20 samples are played in order.
- Underrun: reader latency forced above SAMPLE_DIV.
  - Underrun=1.
  - CurSample holds its last value.
  - Played still reaches Length; Done pulses.
- Stop mid-request, then Play 2 cycles later:
  - the stale ReadValid is discarded;
  - the new first ReadEnable is issued only after that stale ReadValid.
- Reset asserted in PLAY: the next cycle all outputs are 0 and the state is IDLE; a subsequent Play works normally.

Source files
------------

// File: rtl/audio_pkg.sv
// ============================================================================
// Module      : audio_pkg
// Description : Shared types and widths for the audio record/playback path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int SAMPLE_W = 12;
    localparam int ADDR_W   = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PLAY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous single-clock FIFO with flush, full/empty and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  C_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so a write into a full FIFO is legal then.
    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/audio_playback.sv
// ============================================================================
// Module      : audio_playback
// Description : Fetches samples from the RAM reader, buffers them and plays
//               them out at a fixed rate through a 12-bit PWM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_playback
    import audio_pkg::*;
#(
    parameter int SAMPLE_DIV = 2268,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_play,
    input  logic                i_stop,
    input  logic [ADDR_W-1:0]   i_length,
    output logic                o_read_enable,
    input  logic                i_read_valid,
    input  logic [SAMPLE_W-1:0] i_sample_in,
    output logic                o_audio_pwm,
    output logic                o_audio_sd,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_underrun
);

    localparam int                 CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int                 TICK_W      = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W:0]     C_DEPTH_LVL = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [TICK_W-1:0]  C_TICK_LOAD = TICK_W'(SAMPLE_DIV - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_done_next;
    logic [ADDR_W-1:0]   r_length;
    logic [ADDR_W-1:0]   r_requested;
    logic [ADDR_W-1:0]   r_played;
    logic                r_outstanding;
    logic                r_discard;
    logic                r_read_en;
    logic                r_done;
    logic                r_underrun;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [SAMPLE_W-1:0] r_pwm_cnt;
    logic [SAMPLE_W-1:0] r_cur_sample;
    logic                r_audio_pwm;

    logic                w_active;
    logic                w_play_acc;
    logic                w_stop_acc;
    logic                w_tick;
    logic                w_pop;
    logic                w_last;
    logic                w_fifo_wr;
    logic                w_can_req;
    logic [CNT_W:0]      w_fill_level;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [SAMPLE_W-1:0] w_fifo_rd_data;

    assign w_active   = (r_state != IDLE);
    assign w_play_acc = i_play && (r_state == IDLE);
    assign w_stop_acc = i_stop && w_active;
    assign w_tick     = (r_state == PLAY) && (r_tick_cnt == '0) && !i_stop;
    assign w_pop      = w_tick && !w_fifo_empty;
    assign w_last     = w_pop && (r_played == r_length - ADDR_W'(1));
    assign w_fifo_wr  = i_read_valid && w_active && !r_discard && !i_stop;

    // The in-flight sample is counted against capacity so it always has a slot.
    assign w_fill_level = {1'b0, w_fifo_count} + (CNT_W + 1)'(r_outstanding);
    assign w_can_req    = w_active && !w_stop_acc
                        && (!r_outstanding || i_read_valid)
                        && (r_requested < r_length)
                        && (w_fill_level < C_DEPTH_LVL);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_stop_acc),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (i_sample_in),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_play) begin
                    if (i_length == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (i_stop) begin
                    w_state_next = IDLE;
                end else if (w_fifo_full ||
                             ((r_requested == r_length) && !r_outstanding)) begin
                    w_state_next = PLAY;
                end
            end
            PLAY: begin
                if (i_stop) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_length      <= '0;
            r_requested   <= '0;
            r_played      <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_read_en     <= 1'b0;
            r_done        <= 1'b0;
            r_underrun    <= 1'b0;
            r_tick_cnt    <= '0;
            r_pwm_cnt     <= '0;
            r_cur_sample  <= '0;
            r_audio_pwm   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_done    <= w_done_next;
            r_read_en <= w_can_req;

            if (w_play_acc) begin
                r_length    <= i_length;
                r_requested <= '0;
                r_played    <= '0;
                r_underrun  <= 1'b0;
            end else begin
                if (w_can_req) begin
                    r_requested <= r_requested + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_played <= r_played + ADDR_W'(1);
                end
                if (w_tick && w_fifo_empty) begin
                    r_underrun <= 1'b1;
                end
            end

            if (w_can_req) begin
                r_outstanding <= 1'b1;
            end else if (i_read_valid) begin
                r_outstanding <= 1'b0;
            end

            // A request abandoned by Stop still returns data; remember to drop it.
            if (i_read_valid) begin
                r_discard <= 1'b0;
            end else if (w_stop_acc && r_outstanding) begin
                r_discard <= 1'b1;
            end

            if ((w_state_next == PLAY) && (r_state != PLAY)) begin
                r_tick_cnt <= C_TICK_LOAD;
            end else if (r_state == PLAY) begin
                r_tick_cnt <= (r_tick_cnt == '0) ? C_TICK_LOAD : r_tick_cnt - TICK_W'(1);
            end

            if (r_state == IDLE) begin
                r_cur_sample <= '0;
            end else if (w_pop) begin
                r_cur_sample <= w_fifo_rd_data;
            end

            r_pwm_cnt   <= r_pwm_cnt + SAMPLE_W'(1);
            r_audio_pwm <= (r_pwm_cnt < r_cur_sample);
        end
    end

    assign o_read_enable = r_read_en;
    assign o_audio_pwm   = r_audio_pwm;
    assign o_audio_sd    = (r_state == FILL) || (r_state == PLAY);
    assign o_busy        = w_active;
    assign o_done        = r_done;
    assign o_underrun    = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_audio_playback.sv
// ============================================================================
// Module      : tb_audio_playback
// Description : Self-checking bench for audio_playback with a reader model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_audio_playback;
    import audio_pkg::*;

    localparam int C_DIV   = 64;
    localparam int C_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_play = 1'b0;
    logic        i_stop = 1'b0;
    logic [22:0] i_length = '0;
    logic        i_read_valid = 1'b0;
    logic [11:0] i_sample_in = '0;
    logic        o_read_enable;
    logic        o_audio_pwm;
    logic        o_audio_sd;
    logic        o_busy;
    logic        o_done;
    logic        o_underrun;

    audio_playback #(
        .SAMPLE_DIV (C_DIV),
        .FIFO_DEPTH (C_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_play        (i_play),
        .i_stop        (i_stop),
        .i_length      (i_length),
        .o_read_enable (o_read_enable),
        .i_read_valid  (i_read_valid),
        .i_sample_in   (i_sample_in),
        .o_audio_pwm   (o_audio_pwm),
        .o_audio_sd    (o_audio_sd),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_underrun    (o_underrun)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    logic [11:0] tbl [0:31];
    int          idx = 0;
    int          lat = 9;
    bit          pend = 0;
    bit          stale = 0;
    int          cd = 0;
    logic [11:0] pend_data = '0;
    int          stale_cyc = 0;
    logic [11:0] exp_q [$];
    int          n_re = 0, n_done = 0, n_samp = 0, first_re_cyc = -1, last_chg = -1, max_cnt = 0;
    bit          chk_space = 0;
    bit          mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reader: answers each ReadEnable with the next table entry after `lat` cycles.
    initial begin
        forever begin
            @(posedge clk); #1;
            i_read_valid = 1'b0;
            if (pend) begin
                if (cd == 0) begin
                    i_read_valid = 1'b1;
                    i_sample_in  = pend_data;
                    pend = 0;
                    if (stale) begin
                        stale = 0;
                        stale_cyc = cyc + 1;
                    end else begin
                        exp_q.push_back(pend_data);
                    end
                end else begin
                    cd--;
                end
            end
            if (o_read_enable && !rst) begin
                pend = 1;
                cd = lat - 1;
                pend_data = tbl[idx % 32];
                idx++;
            end
        end
    end

    // Per-cycle compare against the behavioural model.
    initial begin
        logic [11:0] p_cur;
        bit          p_pend, exp_pwm, pwm_v;
        int          m_cnt;
        p_cur = '0; p_pend = 0; exp_pwm = 0; pwm_v = 0; m_cnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (pwm_v) check("pwm", o_audio_pwm, exp_pwm);
                check("busy_vs_sd", o_busy, o_audio_sd);
                check("fifo_le_depth", 32'(int'(dut.w_fifo_count) <= C_DEPTH), 1);
                if (int'(dut.w_fifo_count) > max_cnt) max_cnt = int'(dut.w_fifo_count);
                if (o_read_enable) begin
                    n_re++;
                    if (first_re_cyc < 0) first_re_cyc = cyc;
                    check("re_only_busy", o_busy, 1);
                    check("re_while_outstanding", p_pend, 0);
                    check("re_while_full", 32'(int'(dut.w_fifo_count) < C_DEPTH), 1);
                end
                if (o_done) n_done++;
                if (dut.r_cur_sample != p_cur) begin
                    if (dut.r_cur_sample != 12'd0) begin
                        if (exp_q.size() == 0) check("sample_unexpected", dut.r_cur_sample, 0);
                        else check("sample_order", dut.r_cur_sample, exp_q.pop_front());
                        n_samp++;
                        if (chk_space && last_chg >= 0) check("sample_spacing", cyc - last_chg, C_DIV);
                        last_chg = cyc;
                    end else begin
                        check("cur_zero_while_busy", o_busy, 0);
                    end
                end
            end
            p_cur   = dut.r_cur_sample;
            p_pend  = pend;
            exp_pwm = rst ? 1'b0 : (m_cnt < int'(p_cur));
            pwm_v   = pwm_v || rst;
            m_cnt   = rst ? 0 : (m_cnt + 1) % 4096;
        end
    end

    task automatic do_play(input int len, input bit normal);
        @(posedge clk); #1;
        i_play = 1'b1;
        i_length = 23'(len);
        n_re = 0; n_done = 0; n_samp = 0; first_re_cyc = -1; last_chg = -1; max_cnt = 0;
        @(posedge clk); #1;
        i_play = 1'b0;
        check("underrun_cleared", o_underrun, 0);
        if (len != 0) begin
            check("busy_after_play", o_busy, 1);
            check("sd_after_play", o_audio_sd, 1);
            check("re_at_play", o_read_enable, 0);
            @(posedge clk); #1;
            check(normal ? "first_re" : "first_re_held", o_read_enable, normal ? 1 : 0);
        end else begin
            check("len0_busy", o_busy, 0);
            check("len0_done", o_done, 1);
            check("len0_re", o_read_enable, 0);
            @(posedge clk); #1;
            check("len0_done_pulse", o_done, 0);
            check("len0_busy_after", o_busy, 0);
        end
    endtask

    task automatic wait_done(input int bound);
        bit seen;
        seen = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1;
                break;
            end
        end
        check("done_timeout", seen, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_stop();
        @(posedge clk); #1;
        i_stop = 1'b1;
        stale = pend;
        @(posedge clk); #1;
        i_stop = 1'b0;
        check("stop_busy", o_busy, 0);
        check("stop_sd", o_audio_sd, 0);
        check("stop_done", o_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;
        check("rst_re", o_read_enable, 0);
        check("rst_pwm", o_audio_pwm, 0);
        check("rst_sd", o_audio_sd, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_underrun", o_underrun, 0);
        check("rst_cur", dut.r_cur_sample, 0);

        // Basic playback
        lat = 9; idx = 0; chk_space = 1;
        tbl[0] = 12'd100; tbl[1] = 12'd2000; tbl[2] = 12'd4095;
        do_play(3, 1);
        wait_done(2000);
        check("basic_re", n_re, 3);
        check("basic_done", n_done, 1);
        check("basic_samples", n_samp, 3);
        check("basic_left", exp_q.size(), 0);
        check("basic_underrun", o_underrun, 0);

        // Length zero
        do_play(0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("len0_no_re", n_re, 0);

        // FIFO full
        lat = 3; idx = 0;
        for (int i = 0; i < 20; i++) tbl[i] = 12'(100 + 37 * i);
        do_play(20, 1);
        wait_done(5000);
        check("full_max_count", max_cnt, 8);
        check("full_re", n_re, 20);
        check("full_samples", n_samp, 20);
        check("full_done", n_done, 1);
        check("full_left", exp_q.size(), 0);
        check("full_underrun", o_underrun, 0);

        // Underrun
        lat = 150; idx = 0; chk_space = 0;
        for (int i = 0; i < 20; i++) tbl[i] = 12'(50 + 100 * i);
        do_play(20, 1);
        wait_done(12000);
        check("ur_flag", o_underrun, 1);
        check("ur_samples", n_samp, 20);
        check("ur_done", n_done, 1);
        check("ur_left", exp_q.size(), 0);
        chk_space = 1;

        // Stop mid-request, then Play two cycles later
        lat = 9; idx = 0;
        for (int i = 0; i < 5; i++) tbl[i] = 12'(111 * (i + 1));
        do_play(5, 1);
        repeat (2) @(posedge clk);
        #1;
        do_stop();
        idx = 0;
        tbl[0] = 12'd333; tbl[1] = 12'd444; tbl[2] = 12'd555;
        do_play(3, 0);
        wait_done(2000);
        check("stop_re_after_stale", 32'(first_re_cyc > stale_cyc), 1);
        check("stop_samples", n_samp, 3);
        check("stop_run_done", n_done, 1);
        check("stop_left", exp_q.size(), 0);

        // Reset during PLAY
        lat = 3; idx = 0;
        for (int i = 0; i < 20; i++) tbl[i] = 12'(900 + 13 * i);
        do_play(20, 1);
        reached = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (dut.r_state == PLAY) begin
                reached = 1;
                break;
            end
        end
        check("reach_play", reached, 1);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rp_re", o_read_enable, 0);
        check("rp_pwm", o_audio_pwm, 0);
        check("rp_sd", o_audio_sd, 0);
        check("rp_busy", o_busy, 0);
        check("rp_done", o_done, 0);
        check("rp_underrun", o_underrun, 0);
        check("rp_state_idle", 32'(dut.r_state == IDLE), 1);
        check("rp_cur", dut.r_cur_sample, 0);
        @(negedge clk);
        pend = 0; stale = 0;
        exp_q.delete();

        lat = 9; idx = 0;
        tbl[0] = 12'd1234; tbl[1] = 12'd17; tbl[2] = 12'd3000;
        do_play(3, 1);
        wait_done(2000);
        check("rp_after_re", n_re, 3);
        check("rp_after_samples", n_samp, 3);
        check("rp_after_done", n_done, 1);
        check("rp_after_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
